// File: rtl/fetch.sv
// ---------------------------------------------------------------------------
// fetch -- instruction fetch stage for a simple in-order pipeline.
//
// Holds the fetch PC (fpc) and keeps at most one instruction-memory request
// in flight. It delivers fetched words into the IF/ID register
// (instruction / pc_address / valid).
//
// A one-entry skid buffer catches a response that arrives while decode is
// stalled. No new request is issued until that entry has drained.
//
// A redirect from execute does three things. It retargets fpc, it flushes
// IF/ID and the skid buffer, and it marks any in-flight request so that the
// stale response is dropped (the KILL state).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall                    decode hold; IF/ID frozen while high
//   redirect_en/addr         taken control transfer and its target PC
//   imem_req_valid/addr/ready  request handshake to instruction memory
//   imem_rsp_valid/data      response from instruction memory
//   instruction, pc_address, valid   IF/ID register toward decode
//   fetch_count              (only with FETCH_PERF_CNT_EN) number of IF/ID
//                            loads carrying a valid instruction
//
// Configuration macro: FETCH_PERF_CNT_EN enables the fetch_count counter.
// ---------------------------------------------------------------------------
module fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_addr,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] instruction,
    output logic [31:0] pc_address,
    output logic        valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    // IDLE: nothing outstanding; WAIT: one request whose response we keep;
    // KILL: one request whose response must be thrown away.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        KILL = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] fpc;
    logic [31:0] fpc_next;
    logic [31:0] req_pc;
    logic [31:0] req_pc_next;

    logic        buf_valid;
    logic        buf_valid_next;
    logic [31:0] buf_insn;
    logic [31:0] buf_insn_next;
    logic [31:0] buf_pc;
    logic [31:0] buf_pc_next;

    logic [31:0] insn_next;
    logic [31:0] pc_next;
    logic        valid_next;

    // High when a response for a live (not killed) request arrives this cycle.
    logic        rsp_keep;

    assign imem_req_addr = fpc;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic, request generation, fpc update and IF/ID / skid
    // buffer steering.
    always_comb begin
        state_next     = state;
        fpc_next       = fpc;
        req_pc_next    = req_pc;
        buf_valid_next = buf_valid;
        buf_insn_next  = buf_insn;
        buf_pc_next    = buf_pc;
        insn_next      = instruction;
        pc_next        = pc_address;
        valid_next     = valid;
        imem_req_valid = 1'b0;
        rsp_keep       = 1'b0;

        case (state)
            IDLE: begin
                // No new request while the skid buffer still holds a word.
                // The request is retracted if a redirect shows up, so the
                // wrong-path address never reaches memory.
                imem_req_valid = !buf_valid && !rst && !redirect_en;
                if (imem_req_valid && imem_req_ready) begin
                    req_pc_next = fpc;
                    fpc_next    = fpc + 32'd4;
                    state_next  = WAIT;
                end
            end
            WAIT: begin
                if (redirect_en) begin
                    // A response arriving with the redirect is wrong-path.
                    // Drop it now. Otherwise wait for the response in KILL.
                    state_next = imem_rsp_valid ? IDLE : KILL;
                end else if (imem_rsp_valid) begin
                    state_next = IDLE;
                    rsp_keep   = 1'b1;
                end
            end
            KILL: begin
                // A response retires the killed request even if another
                // redirect arrives in the same cycle.
                if (imem_rsp_valid) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (redirect_en) begin
            // A redirect wins over stall. It flushes everything younger than
            // the branch: IF/ID and the skid buffer.
            fpc_next       = redirect_addr;
            valid_next     = 1'b0;
            insn_next      = NOP_INSN;
            buf_valid_next = 1'b0;
        end else if (stall) begin
            // IF/ID frozen. A fresh response is parked in the skid buffer.
            // The buffer is always empty in WAIT, because no request issues
            // while it is full.
            if (rsp_keep) begin
                buf_valid_next = 1'b1;
                buf_insn_next  = imem_rsp_data;
                buf_pc_next    = req_pc;
            end
        end else if (rsp_keep) begin
            valid_next = 1'b1;
            insn_next  = imem_rsp_data;
            pc_next    = req_pc;
        end else if (buf_valid) begin
            valid_next     = 1'b1;
            insn_next      = buf_insn;
            pc_next        = buf_pc;
            buf_valid_next = 1'b0;
        end else begin
            valid_next = 1'b0;
            insn_next  = NOP_INSN;
        end
    end

    // Datapath registers: fetch PC, request PC, skid buffer, IF/ID.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpc         <= RESET_PC;
            req_pc      <= 32'd0;
            buf_valid   <= 1'b0;
            buf_insn    <= NOP_INSN;
            buf_pc      <= 32'd0;
            instruction <= NOP_INSN;
            pc_address  <= 32'd0;
            valid       <= 1'b0;
        end else begin
            fpc         <= fpc_next;
            req_pc      <= req_pc_next;
            buf_valid   <= buf_valid_next;
            buf_insn    <= buf_insn_next;
            buf_pc      <= buf_pc_next;
            instruction <= insn_next;
            pc_address  <= pc_next;
            valid       <= valid_next;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Counts IF/ID loads that carry a valid instruction. A held (stalled)
    // instruction is not counted again.
    logic load_ifid;

    assign load_ifid = !redirect_en && !stall && (rsp_keep || buf_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= 32'd0;
        end else if (load_ifid) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`endif

endmodule
